// File: rtl/ctech_lib_glitch_filt.sv
// ----------------------------------------------------------------------------
// ctech_lib_glitch_filt
// Glitch filter and synchronizer for slow, asynchronous control inputs.
// The raw input is passed through a SYNC_STAGES-deep synchronizer. A change
// reaches the output only after the synchronized level has disagreed with
// the output for FILT_CYC consecutive cycles.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth (2..4)
//   FILT_CYC     cycles of disagreement needed before the output changes (1..255)
//   RST_VAL      reset/clear value of the sync chain and output
//
// Ports:
//   clk     block clock
//   rst     asynchronous active-high reset
//   d       raw asynchronous input
//   clr     synchronous clear, active-high
//   o       filtered, synchronized level
//   busy    high while a candidate change is being qualified
//   o_rise  one-cycle pulse on a rising edge of o (edge-detect build only)
//   o_fall  one-cycle pulse on a falling edge of o (edge-detect build only)
//
// Build option:
//   CTECH_LIB_GLITCH_FILT_EDGE_EN  when defined, o_rise/o_fall are registered
//   edge pulses; otherwise they are tied to 0 and no edge flops exist.
// ----------------------------------------------------------------------------
module ctech_lib_glitch_filt #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYC    = 4,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic clr,
    output logic o,
    output logic busy,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned CW = $clog2(FILT_CYC + 1);

    typedef enum logic {
        IDLE = 1'b0,
        QUAL = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   o_q, o_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchronizer chain; keeps sampling through clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    // Qualification state, counter and output level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            o_q     <= RST_VAL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
        end
    end

    // Next-state logic; clr overrides any qualification in progress.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            o_d     = RST_VAL;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s != o_q) begin
                        // A single-cycle filter commits on first disagreement.
                        if (FILT_CYC == 1) begin
                            o_d = s;
                        end else begin
                            cnt_d   = CW'(1);
                            state_d = QUAL;
                        end
                    end
                end
                QUAL: begin
                    if (s == o_q) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (cnt_q == CW'(FILT_CYC - 1)) begin
                        o_d     = s;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign o    = o_q;
    assign busy = (state_q == QUAL);

`ifdef CTECH_LIB_GLITCH_FILT_EDGE_EN
    logic rise_q, fall_q;

    // Pulses land in the same cycle that o first shows its new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= o_d & ~o_q;
            fall_q <= ~o_d & o_q;
        end
    end

    assign o_rise = rise_q;
    assign o_fall = fall_q;
`else
    assign o_rise = 1'b0;
    assign o_fall = 1'b0;
`endif

endmodule

// File: tb/tb_ctech_lib_glitch_filt.sv
module tb_ctech_lib_glitch_filt;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d   = 1'b1;
    logic clr = 1'b0;

    logic o0, busy0, rise0, fall0;
    logic o1, busy1, rise1, fall1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Default configuration.
    ctech_lib_glitch_filt u_dut0 (
        .clk    (clk),
        .rst    (rst),
        .d      (d),
        .clr    (clr),
        .o      (o0),
        .busy   (busy0),
        .o_rise (rise0),
        .o_fall (fall0)
    );

    // Single-cycle filter behind a three-flop synchronizer.
    ctech_lib_glitch_filt #(
        .SYNC_STAGES (3),
        .FILT_CYC    (1),
        .RST_VAL     (1'b0)
    ) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .d      (d),
        .clr    (clr),
        .o      (o1),
        .busy   (busy1),
        .o_rise (rise1),
        .o_fall (fall1)
    );

    // Reference model: o follows the synchronized input once the last F
    // samples since the most recent clear/commit all disagree with o.
    typedef struct {
        logic [3:0] sh;    // d samples, sh[0] newest
        logic       o;
        int         run;   // trailing samples disagreeing with o
    } mdl_t;

    typedef struct {
        logic o;
        logic busy;
        logic rise;
        logic fall;
    } exp_t;

`ifdef CTECH_LIB_GLITCH_FILT_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    task automatic mdl_step(input mdl_t st_i, input logic di, input logic ci, input logic ri,
                            input int ss, input int ff, output mdl_t st_o, output exp_t e);
        logic smp;
        logic old;
        st_o = st_i;
        if (ri) begin
            st_o.sh  = 4'b0000;
            st_o.o   = 1'b0;
            st_o.run = 0;
            e = '{o: 1'b0, busy: 1'b0, rise: 1'b0, fall: 1'b0};
            return;
        end
        smp     = st_i.sh[ss-1];
        st_o.sh = {st_i.sh[2:0], di};
        old     = st_i.o;
        if (ci) begin
            st_o.o   = 1'b0;
            st_o.run = 0;
        end else begin
            st_o.run = (smp != st_i.o) ? st_i.run + 1 : 0;
            if (st_o.run >= ff) begin
                st_o.o   = smp;
                st_o.run = 0;
            end
        end
        e.o    = st_o.o;
        e.busy = (st_o.run > 0);
        e.rise = EDGE_EN && st_o.o && !old;
        e.fall = EDGE_EN && !st_o.o && old;
    endtask

    mdl_t m0 = '{sh: 4'b0000, o: 1'b0, run: 0};
    mdl_t m1 = '{sh: 4'b0000, o: 1'b0, run: 0};
    exp_t q0[$];
    exp_t q1[$];

    // Model side: advance on every active edge and queue the expectation.
    always @(posedge clk) begin
        mdl_t nx;
        exp_t e;
        mdl_step(m0, d, clr, rst, 2, 4, nx, e);
        m0 = nx;
        q0.push_back(e);
        mdl_step(m1, d, clr, rst, 3, 1, nx, e);
        m1 = nx;
        q1.push_back(e);
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Monitor side: pop one expectation per DUT per cycle and compare.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q0.size() == 0) begin
            chk("dut0_queue_empty", 1'b1, 1'b0);
        end else begin
            e = q0.pop_front();
            chk("dut0_o",    o0,    e.o);
            chk("dut0_busy", busy0, e.busy);
            chk("dut0_rise", rise0, e.rise);
            chk("dut0_fall", fall0, e.fall);
        end
        if (q1.size() == 0) begin
            chk("dut1_queue_empty", 1'b1, 1'b0);
        end else begin
            e = q1.pop_front();
            chk("dut1_o",    o1,    e.o);
            chk("dut1_busy", busy1, e.busy);
            chk("dut1_rise", rise1, e.rise);
            chk("dut1_fall", fall1, e.fall);
        end
    end

    task automatic tick(input logic dv, input logic cv, input logic rv);
        @(negedge clk);
        d   = dv;
        clr = cv;
        rst = rv;
    endtask

    initial begin
        logic hold_v;
        int   hold_n;

        // Reset held with d high, then released with d low.
        repeat (3) tick(1'b1, 1'b0, 1'b1);
        #1;
        chk("reset_o",    o0,    1'b0);
        chk("reset_busy", busy0, 1'b0);
        repeat (20) tick(1'b0, 1'b0, 1'b0);

        // Clean rise, then clean fall.
        repeat (10) tick(1'b1, 1'b0, 1'b0);
        repeat (10) tick(1'b0, 1'b0, 1'b0);

        // Three-cycle glitch is rejected by the default filter.
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        repeat (10) tick(1'b0, 1'b0, 1'b0);

        // Reset while qualifying; outputs drop without waiting for a clock.
        repeat (4) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        #1;
        chk("midqual_rst_o",    o0,    1'b0);
        chk("midqual_rst_busy", busy0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        repeat (12) tick(1'b0, 1'b0, 1'b0);

        // Clear on the edge that would have committed the rise.
        repeat (5) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        repeat (10) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        repeat (10) tick(1'b0, 1'b0, 1'b0);

        // Randomized hold lengths with occasional clear and reset.
        hold_v = 1'b0;
        hold_n = 0;
        for (int i = 0; i < 2000; i++) begin
            if (hold_n == 0) begin
                hold_v = 1'($urandom_range(0, 1));
                hold_n = int'($urandom_range(1, 8));
            end
            hold_n--;
            tick(hold_v, ($urandom_range(0, 49) == 0), ($urandom_range(0, 199) == 0));
        end

        repeat (4) tick(1'b0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
